// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle carrying a payload and its control bits.
// master drives valid/data/ctrl, slave drives ready.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with one skid entry and fully registered in_ready.
// Define PIPE_STAGE_REG_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    pipe_stage_reg_if.slave         in_if,
    pipe_stage_reg_if.master        out_if
`ifdef PIPE_STAGE_REG_PERF_EN
    ,
    output logic [31:0]             stall_cnt,
    output logic [15:0]             flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_e;

    state_e            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_if.valid & in_ready_q;
    assign out_fire = out_valid_q & out_if.ready;

    assign in_if.ready  = in_ready_q;
    assign out_if.valid = out_valid_q;
    assign out_if.data  = main_data_q;
    assign out_if.ctrl  = main_ctrl_q;

    // Control bits are zeroed whenever a slot becomes a bubble, so out_ctrl
    // needs no gating on the output path; payload bits are left as they were.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else if (flush) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_q     <= S_FULL;
                        out_valid_q <= 1'b1;
                        main_data_q <= in_if.data;
                        main_ctrl_q <= in_if.ctrl;
                    end
                end
                S_FULL: begin
                    if (in_fire && out_fire) begin
                        main_data_q <= in_if.data;
                        main_ctrl_q <= in_if.ctrl;
                    end else if (in_fire) begin
                        state_q     <= S_SKID;
                        in_ready_q  <= 1'b0;
                        skid_data_q <= in_if.data;
                        skid_ctrl_q <= in_if.ctrl;
                    end else if (out_fire) begin
                        state_q     <= S_EMPTY;
                        out_valid_q <= 1'b0;
                        main_ctrl_q <= '0;
                    end
                end
                S_SKID: begin
                    // in_ready is low here, so only a drain can happen.
                    if (out_fire) begin
                        state_q     <= S_FULL;
                        in_ready_q  <= 1'b1;
                        main_data_q <= skid_data_q;
                        main_ctrl_q <= skid_ctrl_q;
                        skid_ctrl_q <= '0;
                    end
                end
                default: begin
                    state_q     <= S_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    main_ctrl_q <= '0;
                    skid_ctrl_q <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_REG_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // A skid entry implies a valid main entry, so out_valid alone tells
    // whether a flush throws something away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid_q && !out_if.ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush && out_valid_q && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: streaming, skid fill,
// flush, asynchronous reset, stall hold and (optionally) the perf counters.
module tb_pipe_stage_reg;

    localparam int DATA_W = 96;
    localparam int CTRL_W = 8;

    logic clk;
    logic rst;
    logic flush;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) in_if ();
    pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) out_if ();

`ifdef PIPE_STAGE_REG_PERF_EN
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_if     (in_if),
        .out_if    (out_if)
`ifdef PIPE_STAGE_REG_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    // Advance one clock; inputs are then changed and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        in_if.valid = v;
        in_if.data  = d;
        in_if.ctrl  = c;
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        out_if.ready = 1'b0;
        drive(1'b0, '0, '0);
        step();
        step();
        check("reset_out_valid", 128'(out_if.valid), 128'd0);
        check("reset_out_ctrl",  128'(out_if.ctrl),  128'd0);
        check("reset_out_data",  128'(out_if.data),  128'd0);
        check("reset_in_ready",  128'(in_if.ready),  128'd1);
        rst = 1'b0;

        // Streaming 1..8 with downstream always ready: one entry per cycle.
        out_if.ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DATA_W'(i), CTRL_W'(i));
            step();
            check($sformatf("stream_valid_%0d", i), 128'(out_if.valid), 128'd1);
            check($sformatf("stream_data_%0d", i),  128'(out_if.data),  128'(i));
            check($sformatf("stream_ready_%0d", i), 128'(in_if.ready),  128'd1);
        end
        drive(1'b0, '0, '0);
        step();
        check("stream_drained_valid", 128'(out_if.valid), 128'd0);
        check("stream_drained_ctrl",  128'(out_if.ctrl),  128'd0);

        // Skid fill: 0xA then 0xB while stalled.
        out_if.ready = 1'b0;
        drive(1'b1, DATA_W'(32'hA), CTRL_W'(8'h01));
        step();
        check("skid_a_data",  128'(out_if.data), 128'hA);
        check("skid_a_ready", 128'(in_if.ready), 128'd1);
        drive(1'b1, DATA_W'(32'hB), CTRL_W'(8'h02));
        step();
        check("skid_b_ready", 128'(in_if.ready), 128'd0);
        check("skid_b_head",  128'(out_if.data), 128'hA);
        check("skid_b_ctrl",  128'(out_if.ctrl), 128'h01);
        drive(1'b0, '0, '0);
        out_if.ready = 1'b1;
        step();
        check("drain_b_data",  128'(out_if.data),  128'hB);
        check("drain_b_ctrl",  128'(out_if.ctrl),  128'h02);
        check("drain_b_valid", 128'(out_if.valid), 128'd1);
        check("drain_b_ready", 128'(in_if.ready),  128'd1);
        step();
        check("drain_empty_valid", 128'(out_if.valid), 128'd0);
        check("drain_empty_ctrl",  128'(out_if.ctrl),  128'd0);
        check("drain_empty_data",  128'(out_if.data),  128'hB);

        // Flush while in SKID with an offered entry 0xC.
        out_if.ready = 1'b0;
        drive(1'b1, DATA_W'(32'h11), CTRL_W'(8'h11));
        step();
        drive(1'b1, DATA_W'(32'h12), CTRL_W'(8'h12));
        step();
        check("flush_pre_ready", 128'(in_if.ready), 128'd0);
        flush = 1'b1;
        drive(1'b1, DATA_W'(32'hC), CTRL_W'(8'h07));
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        check("flush_skid_valid", 128'(out_if.valid), 128'd0);
        check("flush_skid_ctrl",  128'(out_if.ctrl),  128'd0);
        check("flush_skid_ready", 128'(in_if.ready),  128'd1);
        out_if.ready = 1'b1;
        step();
        check("flush_no_c_valid", 128'(out_if.valid), 128'd0);

        // Flush in FULL while a same-cycle input could fire: input is dropped.
        out_if.ready = 1'b0;
        drive(1'b1, DATA_W'(32'h31), CTRL_W'(8'h31));
        step();
        flush = 1'b1;
        drive(1'b1, DATA_W'(32'h32), CTRL_W'(8'h32));
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        check("flush_full_valid", 128'(out_if.valid), 128'd0);
        check("flush_full_ctrl",  128'(out_if.ctrl),  128'd0);

        // Asynchronous reset mid-cycle while FULL with ctrl 0xFF.
        drive(1'b1, DATA_W'(32'h77), CTRL_W'(8'hFF));
        step();
        drive(1'b0, '0, '0);
        check("areset_pre_ctrl", 128'(out_if.ctrl), 128'hFF);
        #2;
        rst = 1'b1;
        #1;
        check("areset_valid", 128'(out_if.valid), 128'd0);
        check("areset_ctrl",  128'(out_if.ctrl),  128'd0);
        check("areset_data",  128'(out_if.data),  128'd0);
        check("areset_ready", 128'(in_if.ready),  128'd1);
        #2;
        rst = 1'b0;
        step();
        out_if.ready = 1'b1;
        drive(1'b1, DATA_W'(32'h21), CTRL_W'(8'h21));
        step();
        drive(1'b0, '0, '0);
        check("post_reset_valid", 128'(out_if.valid), 128'd1);
        check("post_reset_data",  128'(out_if.data),  128'h21);
        step();
        check("post_reset_drain", 128'(out_if.valid), 128'd0);

        // Stall hold: head 0x5 held for 10 cycles.
        out_if.ready = 1'b0;
        drive(1'b1, DATA_W'(32'h5), CTRL_W'(8'h33));
        step();
        drive(1'b0, '0, '0);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("stall_data_%0d", i),  128'(out_if.data),  128'h5);
            check($sformatf("stall_ctrl_%0d", i),  128'(out_if.ctrl),  128'h33);
            check($sformatf("stall_valid_%0d", i), 128'(out_if.valid), 128'd1);
        end
`ifdef PIPE_STAGE_REG_PERF_EN
        check("stall_cnt", 128'(stall_cnt), 128'd10);
`endif
        out_if.ready = 1'b1;
        step();
        check("stall_release_valid", 128'(out_if.valid), 128'd0);

        // Flush while EMPTY (not counted), then while FULL (counted).
        flush = 1'b1;
        step();
        flush = 1'b0;
        out_if.ready = 1'b0;
        drive(1'b1, DATA_W'(32'h9), CTRL_W'(8'h09));
        step();
        drive(1'b0, '0, '0);
        check("fcount_full_valid", 128'(out_if.valid), 128'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fcount_flushed_valid", 128'(out_if.valid), 128'd0);
`ifdef PIPE_STAGE_REG_PERF_EN
        check("flush_cnt", 128'(flush_cnt), 128'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 96: payload bits (PC, imm, operands), with no clearing on flush.
REQ-002 SHALL have parameter CTRL_W, default 8: control bits (wen, mem-write, branch/jump); forced to 0 whenever the stage holds a bubble.
REQ-003 SHALL have port clk  in  1: single clock, rising-edge.
REQ-004 SHALL have port rst  in  1: one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port flush  in  1: synchronous kill of all held entries.
REQ-006 SHALL have port in_valid  in  1: upstream entry present.
REQ-007 SHALL have port in_ready  out  1: stage can accept; registered output.
REQ-008 SHALL have port in_data  in  DATA_W: upstream payload.
REQ-009 SHALL have port in_ctrl  in  CTRL_W: upstream control.
REQ-010 SHALL have port out_valid  out  1: head entry present.
REQ-011 SHALL have port out_ready  in  1: downstream accepts.
REQ-012 SHALL have port out_data  out  DATA_W: head payload.
REQ-013 SHALL have port out_ctrl  out  CTRL_W: head control, 0 when out_valid=0.

Function
REQ-014 SHALL define in-fire = in_valid & in_ready and out-fire = out_valid & out_ready.
REQ-015 SHALL hold a main register and one skid register, giving three states: EMPTY (none held), FULL (main only), SKID (main+skid).
REQ-016 SHALL set in_ready=1 in EMPTY/FULL and 0 in SKID; in_ready depends on no input combinationally.
REQ-017 SHALL implement these transitions, with no flush:
- EMPTY + in-fire -> FULL, main <= input.
- FULL + in-fire + out-fire -> FULL, main <= input.
- FULL + in-fire + no out-fire -> SKID, skid <= input.
- FULL + out-fire only -> EMPTY.
- SKID + out-fire -> FULL, main <= skid.
- All other cases hold state.
REQ-018 SHALL have a latency of 1 cycle from in-fire to out_valid; throughput SHALL be 1 entry/cycle while out_ready=1.
REQ-019 SHALL preserve order: the skid entry always leaves after the main entry; no entry is duplicated or lost.
REQ-020 SHALL give flush the highest priority: next state EMPTY, both valid flags 0, out_ctrl 0, and any same-cycle input dropped.
REQ-021 SHALL leave out_data at its last value when out_valid=0; it is don't-care downstream.
REQ-022 SHALL leave a held head unchanged while out_ready=0 (data, ctrl and valid stable).

Reset
REQ-023 SHALL, on rst asserted, immediately clear out_valid=0, out_ctrl=0, out_data=0, skid contents=0, state EMPTY, and in_ready=1, regardless of clk.
REQ-024 SHALL remove the entry when reset is asserted mid-transfer; the first in-fire after deassertion is accepted normally.

Configuration
REQ-025 SHALL, with PIPE_STAGE_REG_PERF_EN defined, add output stall_cnt[31:0], counting cycles with out_valid=1 & out_ready=0.
REQ-026 SHALL, with PIPE_STAGE_REG_PERF_EN defined, add output flush_cnt[15:0], counting flush cycles that discard at least one valid entry.
REQ-027 SHALL make both counters saturating and cleared by rst only.
REQ-028 SHALL, without PIPE_STAGE_REG_PERF_EN, omit the counter ports and logic entirely, with identical datapath behaviour.

Verification
REQ-029 SHALL cover streaming: out_ready=1, drive in_data 1..8 on consecutive cycles -> out_data 1..8 one cycle later each, no gaps.
REQ-030 SHALL cover skid fill: in_data=0xA then 0xB with out_ready=0 -> in_ready=0 after 0xB; on out_ready=1, out 0xA then 0xB, in_ready=1 after 0xA drains.
REQ-031 SHALL cover flush with an entry: flush in SKID state while in_valid=1, in_data=0xC -> next cycle out_valid=0, out_ctrl=0, 0xC never appears.
REQ-032 SHALL cover async reset: assert rst mid-cycle while FULL with in_ctrl=0xFF -> out_valid and out_ctrl become 0 before the next clk edge, in_ready=1.
REQ-033 SHALL cover stall hold: FULL with out_data=0x5, out_ready=0 for 10 cycles -> out_data/out_ctrl stable; with PIPE_STAGE_REG_PERF_EN, stall_cnt=10.
REQ-034 SHALL cover flush counting: with PIPE_STAGE_REG_PERF_EN, flush while EMPTY, then flush while FULL -> flush_cnt=1.
